// File: rtl/wb_commit_unit_if.sv
// Write-back bundle between the two cores and the register file commit unit.
// The slave modport is the commit unit. The master modport is the driver side (cores, decode and register file).
interface wb_commit_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              c0_valid;
  logic              c0_ready;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_data;
  logic              c1_valid;
  logic              c1_ready;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_data;
  logic              commit_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [ADDR_W-1:0] byp_a1;
  logic [ADDR_W-1:0] byp_a2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;

  modport slave (
    input  c0_valid, c0_addr, c0_data, c1_valid, c1_addr, c1_data,
           commit_stall, byp_a1, byp_a2,
    output c0_ready, c1_ready, wr_en, wr_addr, wr_data,
           wr_en_o, wr_addr_o, wr_data_o,
           byp_hit1, byp_hit2, byp_data1, byp_data2
  );

  modport master (
    output c0_valid, c0_addr, c0_data, c1_valid, c1_addr, c1_data,
           commit_stall, byp_a1, byp_a2,
    input  c0_ready, c1_ready, wr_en, wr_addr, wr_data,
           wr_en_o, wr_addr_o, wr_data_o,
           byp_hit1, byp_hit2, byp_data1, byp_data2
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Shared write-back queue for two cores. It drains up to two register-file writes per cycle.
// A combinational bypass returns the youngest pending value to decode.
module wb_commit_unit #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              reset,
  wb_commit_unit_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, free;

  logic              wr_en_q, wr_en_d, wr_en_o_q, wr_en_o_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_addr_o_q, wr_addr_o_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, wr_data_o_q, wr_data_o_d;

  logic              c0_rdy, c1_rdy, acc0, acc1;
  logic [1:0]        n_enq, n_pop;
  logic [PTR_W-1:0]  wr_ptr1, h1_ptr;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early.
  always_comb begin
    free   = CNT_W'(DEPTH) - count_q;
    c0_rdy = free >= CNT_W'(1);
    c1_rdy = free >= (bus.c0_valid ? CNT_W'(2) : CNT_W'(1));
    acc0   = bus.c0_valid & c0_rdy;
    acc1   = bus.c1_valid & c1_rdy;
  end

  assign bus.c0_ready  = c0_rdy;
  assign bus.c1_ready  = c1_rdy;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_en_o   = wr_en_o_q;
  assign bus.wr_addr_o = wr_addr_o_q;
  assign bus.wr_data_o = wr_data_o_q;

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_ptr1    = wr_ptr_q + PTR_W'(acc0);
    if (acc0) begin
      mem_addr_d[wr_ptr_q] = bus.c0_addr;
      mem_data_d[wr_ptr_q] = bus.c0_data;
    end
    if (acc1) begin
      mem_addr_d[wr_ptr1] = bus.c1_addr;
      mem_data_d[wr_ptr1] = bus.c1_data;
    end
    n_enq = {1'b0, acc0} + {1'b0, acc1};

    h1_ptr      = rd_ptr_q + PTR_W'(1);
    n_pop       = 2'd0;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    wr_en_o_d   = 1'b0;
    wr_addr_o_d = '0;
    wr_data_o_d = '0;
    if (!bus.commit_stall) begin
      if (count_q >= CNT_W'(2)) begin
        n_pop = 2'd2;
        // Two heads to the same register: only the younger one is written, and both entries retire.
        if (mem_addr_q[rd_ptr_q] == mem_addr_q[h1_ptr]) begin
          wr_en_d   = 1'b1;
          wr_addr_d = mem_addr_q[h1_ptr];
          wr_data_d = mem_data_q[h1_ptr];
        end else begin
          wr_en_d     = 1'b1;
          wr_addr_d   = mem_addr_q[rd_ptr_q];
          wr_data_d   = mem_data_q[rd_ptr_q];
          wr_en_o_d   = 1'b1;
          wr_addr_o_d = mem_addr_q[h1_ptr];
          wr_data_o_d = mem_data_q[h1_ptr];
        end
      end else if (count_q == CNT_W'(1)) begin
        n_pop     = 2'd1;
        wr_en_d   = 1'b1;
        wr_addr_d = mem_addr_q[rd_ptr_q];
        wr_data_d = mem_data_q[rd_ptr_q];
      end
    end

    rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
    count_d  = count_q + CNT_W'(n_enq) - CNT_W'(n_pop);
  end

  // Search from oldest to youngest: output port 0, then port 1, then queue entries from rd_ptr. The last match wins.
  always_comb begin
    bus.byp_hit1  = 1'b0;
    bus.byp_data1 = '0;
    bus.byp_hit2  = 1'b0;
    bus.byp_data2 = '0;
    if (wr_en_q && wr_addr_q == bus.byp_a1) begin
      bus.byp_hit1  = 1'b1;
      bus.byp_data1 = wr_data_q;
    end
    if (wr_en_q && wr_addr_q == bus.byp_a2) begin
      bus.byp_hit2  = 1'b1;
      bus.byp_data2 = wr_data_q;
    end
    if (wr_en_o_q && wr_addr_o_q == bus.byp_a1) begin
      bus.byp_hit1  = 1'b1;
      bus.byp_data1 = wr_data_o_q;
    end
    if (wr_en_o_q && wr_addr_o_q == bus.byp_a2) begin
      bus.byp_hit2  = 1'b1;
      bus.byp_data2 = wr_data_o_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i < 32'(count_q)) begin
        if (mem_addr_q[rd_ptr_q + PTR_W'(i)] == bus.byp_a1) begin
          bus.byp_hit1  = 1'b1;
          bus.byp_data1 = mem_data_q[rd_ptr_q + PTR_W'(i)];
        end
        if (mem_addr_q[rd_ptr_q + PTR_W'(i)] == bus.byp_a2) begin
          bus.byp_hit2  = 1'b1;
          bus.byp_data2 = mem_data_q[rd_ptr_q + PTR_W'(i)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_o_q   <= 1'b0;
      wr_addr_o_q <= '0;
      wr_data_o_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_o_q   <= wr_en_o_d;
      wr_addr_o_q <= wr_addr_o_d;
      wr_data_o_q <= wr_data_o_d;
    end
  end

  // Entry contents need no reset: count alone decides which entries are live.
  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end
endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit. It runs directed and random traffic against a queue-based reference model.
module tb_wb_commit_unit;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  wb_commit_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_commit_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: pending writes in age order, plus the expected contents of the output registers.
  ent_t              mq[$];
  logic              e_en0, e_en1;
  logic [ADDR_W-1:0] e_a0, e_a1;
  logic [DATA_W-1:0] e_d0, e_d1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    e_en0 = 1'b0; e_a0 = '0; e_d0 = '0;
    e_en1 = 1'b0; e_a1 = '0; e_d1 = '0;
  endtask

  task automatic byp_expect(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (e_en0 && e_a0 == a) begin hit = 1'b1; d = e_d0; end
    if (e_en1 && e_a1 == a) begin hit = 1'b1; d = e_d1; end
    foreach (mq[i]) if (mq[i].a == a) begin hit = 1'b1; d = mq[i].d; end
  endtask

  // One clock cycle: drive the inputs, check every output against the model, then advance the model across the edge.
  task automatic cycle(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic st, input logic [ADDR_W-1:0] b1, input logic [ADDR_W-1:0] b2);
    int                cnt;
    logic              r0, r1, h;
    logic [DATA_W-1:0] bd;
    ent_t              h0, hh1, e;
    logic              n_en0, n_en1;
    logic [ADDR_W-1:0] n_a0, n_a1;
    logic [DATA_W-1:0] n_d0, n_d1;
    @(negedge clk);
    bus.c0_valid = v0; bus.c0_addr = a0; bus.c0_data = d0;
    bus.c1_valid = v1; bus.c1_addr = a1; bus.c1_data = d1;
    bus.commit_stall = st; bus.byp_a1 = b1; bus.byp_a2 = b2;
    #1;
    cnt = mq.size();
    r0  = (cnt < DEPTH);
    r1  = v0 ? (cnt <= DEPTH - 2) : (cnt < DEPTH);
    chk("c0_ready", 64'(bus.c0_ready), 64'(r0));
    chk("c1_ready", 64'(bus.c1_ready), 64'(r1));
    chk("wr_en", 64'(bus.wr_en), 64'(e_en0));
    chk("wr_addr", 64'(bus.wr_addr), 64'(e_a0));
    chk("wr_data", 64'(bus.wr_data), 64'(e_d0));
    chk("wr_en_o", 64'(bus.wr_en_o), 64'(e_en1));
    chk("wr_addr_o", 64'(bus.wr_addr_o), 64'(e_a1));
    chk("wr_data_o", 64'(bus.wr_data_o), 64'(e_d1));
    byp_expect(b1, h, bd);
    chk("byp_hit1", 64'(bus.byp_hit1), 64'(h));
    chk("byp_data1", 64'(bus.byp_data1), 64'(bd));
    byp_expect(b2, h, bd);
    chk("byp_hit2", 64'(bus.byp_hit2), 64'(h));
    chk("byp_data2", 64'(bus.byp_data2), 64'(bd));

    n_en0 = 1'b0; n_a0 = '0; n_d0 = '0;
    n_en1 = 1'b0; n_a1 = '0; n_d1 = '0;
    if (!st && cnt >= 2) begin
      h0 = mq.pop_front();
      hh1 = mq.pop_front();
      if (h0.a == hh1.a) begin
        n_en0 = 1'b1; n_a0 = hh1.a; n_d0 = hh1.d;
      end else begin
        n_en0 = 1'b1; n_a0 = h0.a; n_d0 = h0.d;
        n_en1 = 1'b1; n_a1 = hh1.a; n_d1 = hh1.d;
      end
    end else if (!st && cnt == 1) begin
      h0 = mq.pop_front();
      n_en0 = 1'b1; n_a0 = h0.a; n_d0 = h0.d;
    end
    if (v0 && r0) begin e.a = a0; e.d = d0; mq.push_back(e); end
    if (v1 && r1) begin e.a = a1; e.d = d1; mq.push_back(e); end
    @(posedge clk);
    e_en0 = n_en0; e_a0 = n_a0; e_d0 = n_d0;
    e_en1 = n_en1; e_a1 = n_a1; e_d1 = n_d1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, '0, '0, 0, '0, '0, 0, 5'd3, 5'd9);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.c0_valid = 1'b1; bus.c1_valid = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    reset = 1'b0;
    bus.c0_valid = 1'b0; bus.c1_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.c0_valid = 1'b0; bus.c0_addr = '0; bus.c0_data = '0;
    bus.c1_valid = 1'b0; bus.c1_addr = '0; bus.c1_data = '0;
    bus.commit_stall = 1'b0; bus.byp_a1 = '0; bus.byp_a2 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Single write, then both ports idle.
    cycle(1, 5'd3, 32'hA5A5A5A5, 0, '0, '0, 0, 5'd3, 5'd4);
    cycle(0, '0, '0, 0, '0, '0, 0, 5'd3, 5'd4);
    #1;
    chk("plan_single_data", 64'(bus.wr_data), 64'h00000000A5A5A5A5);
    chk("plan_single_en_o", 64'(bus.wr_en_o), 64'd0);
    idle(2);

    // Two distinct registers in one cycle.
    cycle(1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 0, 5'd5, 5'd6);
    cycle(0, '0, '0, 0, '0, '0, 0, 5'd5, 5'd6);
    #1;
    chk("plan_pair_addr_o", 64'(bus.wr_addr_o), 64'd6);
    chk("plan_pair_data_o", 64'(bus.wr_data_o), 64'h22);
    idle(1);

    // Same register from both cores: the younger write survives.
    cycle(1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 0, 5'd7, 5'd0);
    cycle(0, '0, '0, 0, '0, '0, 0, 5'd7, 5'd0);
    #1;
    chk("plan_same_data", 64'(bus.wr_data), 64'h2);
    chk("plan_same_en_o", 64'(bus.wr_en_o), 64'd0);
    idle(1);

    // Fill under stall with both cores, then keep offering at full.
    for (int k = 0; k < 6; k++)
      cycle(1, 5'(k), 32'(100 + k), 1, 5'(k + 10), 32'(200 + k), 1, 5'd2, 5'd12);
    #1;
    chk("plan_full_c0_ready", 64'(bus.c0_ready), 64'd0);
    // While full, a pop in the same cycle must not raise ready.
    cycle(1, 5'd20, 32'h55, 1, 5'd21, 32'h66, 0, 5'd1, 5'd11);
    idle(5);

    // Reach count 7 with core 0 only, then offer both cores.
    for (int k = 0; k < 7; k++) cycle(1, 5'(k + 1), 32'(300 + k), 0, '0, '0, 1, 5'd3, 5'd7);
    cycle(1, 5'd8, 32'h308, 1, 5'd9, 32'h309, 1, 5'd8, 5'd9);
    cycle(1, 5'd8, 32'h400, 1, 5'd9, 32'h401, 0, 5'd8, 5'd9);
    idle(6);

    // Bypass returns the younger of two queued writes to the same register.
    cycle(1, 5'd9, 32'h33, 1, 5'd9, 32'h44, 1, 5'd9, 5'd10);
    cycle(0, '0, '0, 0, '0, '0, 1, 5'd9, 5'd10);
    #1;
    chk("plan_byp_data1", 64'(bus.byp_data1), 64'h44);
    chk("plan_byp_hit2", 64'(bus.byp_hit2), 64'd0);
    idle(3);

    // Reset discards queued entries.
    cycle(1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 1, 5'd1, 5'd2);
    cycle(1, 5'd3, 32'hC, 1, 5'd4, 32'hD, 1, 5'd1, 5'd2);
    cycle(1, 5'd5, 32'hE, 0, '0, '0, 1, 5'd1, 5'd2);
    do_reset();
    bus.commit_stall = 1'b0;
    #1;
    chk("plan_rst_c0_ready", 64'(bus.c0_ready), 64'd1);
    chk("plan_rst_c1_ready", 64'(bus.c1_ready), 64'd1);
    chk("plan_rst_hit1", 64'(bus.byp_hit1), 64'd0);
    chk("plan_rst_wr_en", 64'(bus.wr_en), 64'd0);
    idle(3);

    // Random traffic on a small address range, so that same-register collisions happen often.
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_commit_unit.md
# wb_commit_unit

Write-back commit unit for the dual-core processor. It sits directly upstream of the shared register file. It accepts register write-back results from core 0 and core 1 through valid/ready handshakes, orders them in one shared 8-entry queue, and drains up to two writes per cycle onto the register file's two write ports. It also provides a read bypass so decode sees results that are still queued or in flight.

## Interface
Parameters:
- DEPTH, 8, queue entries; power of two, at least 2
- DATA_W, 32, write data width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- c0_valid  in  1  core 0 write-back request
- c0_ready  out  1  core 0 request accepted this cycle when c0_valid && c0_ready
- c0_addr  in  ADDR_W  core 0 destination register
- c0_data  in  DATA_W  core 0 result
- c1_valid, c1_ready, c1_addr, c1_data  same as c0_*, for core 1
- commit_stall  in  1  when high, no queue entries are popped
- wr_en  out  1  port 0 write valid
- wr_addr  out  ADDR_W  port 0 register address
- wr_data  out  DATA_W  port 0 write data
- wr_en_o  out  1  port 1 write valid
- wr_addr_o  out  ADDR_W  port 1 register address
- wr_data_o  out  DATA_W  port 1 write data
- byp_a1, byp_a2  in  ADDR_W  decode source addresses
- byp_hit1, byp_hit2  out  1  a pending write to byp_aN exists
- byp_data1, byp_data2  out  DATA_W  youngest pending value for byp_aN; 0 when no hit

## Operation
- Queue: circular buffer with rd_ptr, wr_ptr and count (0..DEPTH); free = DEPTH - count, from registered count only.
- Ready: c0_ready = (free >= 1); c1_ready = (free >= (c0_valid ? 2 : 1)). Pops in the same cycle do not raise ready.
- Enqueue order within one cycle: the core 0 entry is written first (older), then the core 1 entry. If only one core is accepted, it takes slot wr_ptr.
- Pop (commit_stall low):
  - count >= 2: pop heads H0 (older) and H1. If H0.addr != H1.addr, H0 goes to port 0 and H1 goes to port 1. If the addresses are equal, only H1 goes to port 0, wr_en_o = 0, and both entries are popped; the older write is dropped.
  - count == 1: pop H0 to port 0, wr_en_o = 0.
  - count == 0: no pop.
- commit_stall high: no pop; wr_en = wr_en_o = 0 on the next cycle. Enqueue continues.
- Write outputs are registered. When a port is not enabled, its addr and data are driven to 0.
- No special handling of address 0.
- Bypass is combinational. For each byp_aN, search the registered write outputs (port 1 is younger than port 0) and all valid queue entries. The youngest matching write wins, where queue entries are younger than the output registers and queue age runs from rd_ptr upward.
- Pointers wrap modulo DEPTH. count is updated by (enqueued − popped) in the same edge.

## Timing
- Reset: count = 0, pointers = 0, all queue contents invalid, wr_en = wr_en_o = 0, wr_addr/wr_data/wr_addr_o/wr_data_o = 0. After reset, c0_ready = c1_ready = 1 and byp_hit1 = byp_hit2 = 0.
- Reset mid-operation discards all queued and in-flight writes; no write is issued in the cycle after reset.
- Latency: a request accepted at edge N, with an empty queue and no stall, is popped at edge N+1. wr_en is high during cycle N+1 to N+2, and the register file captures it in that cycle.
- Bypass hit is visible from the cycle after edge N until the cycle after the pop edge, inclusive.
- Throughput: 2 writes/cycle sustained.
- Full boundary: at count == DEPTH both readys are low, even if a pop occurs that cycle.
- Simultaneous enqueue and pop at count == DEPTH−1: only core 0 can be accepted; core 1 waits.

## Test plan
- Reset, then core 0 writes (addr 3, 0xA5A5A5A5) → next cycle wr_en=1, wr_addr=3, wr_data=0xA5A5A5A5; wr_en_o=0; the following cycle both enables are 0.
- Same cycle: core 0 writes (5, 0x11) and core 1 writes (6, 0x22) → one cycle later port 0 = (5, 0x11) and port 1 = (6, 0x22), both enabled.
- Same cycle: core 0 writes (7, 0x1) and core 1 writes (7, 0x2) → only port 0 enabled, with (7, 0x2); port 1 disabled with addr/data 0.
- Hold commit_stall=1 and offer both cores each cycle → count reaches 8 after 4 cycles with both readys low; at count 7, c1_ready=0 while c0_valid=1. Release stall → 2 writes/cycle drain in order with no loss; wrap-around is exercised.
- While addr 9 is queued as 0x33 (older) and 0x44 (younger), byp_a1=9 → byp_hit1=1, byp_data1=0x44; byp_a2=10 → byp_hit2=0, byp_data2=0.
- Fill 5 entries under stall, assert reset for one cycle → no write is issued after reset, count=0, c0_ready=c1_ready=1, byp_hit=0.
